runner_sprite_drawer: RTL and testbench

Downstream consumer of the runner's vertical position. On each frame `update` pulse it samples the current runner top-row `y_in`, erases the runner rectangle at the previously drawn position, then draws it at the new position. Output is a one-pixel-per-cycle `x`/`y`/`colour`/`plot` stream into the 160x120 VGA adapter frame buffer.

---
 rtl/runner_pkg.sv | 21 ++
 rtl/runner_sprite_drawer_if.sv | 26 ++
 rtl/sprite_scan_counter.sv | 38 +++
 rtl/runner_sprite_drawer.sv | 137 +++++++++++++
 tb/tb_runner_sprite_drawer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/runner_pkg.sv
// Shared constants and types for the runner movement and drawer blocks.
package runner_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    // Common reset row for the movement block and the drawer.
    localparam logic [6:0] GROUND_Y = 7'd108;

    localparam logic [2:0] COLOUR_RUNNER = 3'b111;
    localparam logic [2:0] COLOUR_BG     = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ERASE,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/runner_sprite_drawer_if.sv
// Frame-tick input and pixel-stream output bundle of the runner drawer.
interface runner_sprite_drawer_if;

    logic       update;
    logic [6:0] y_in;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       overrun;

    // Upstream side: issues frame ticks and observes the pixel stream.
    modport master (
        output update, y_in,
        input  x_out, y_out, colour, plot, busy, done, overrun
    );

    // Drawer side.
    modport slave (
        input  update, y_in,
        output x_out, y_out, colour, plot, busy, done, overrun
    );

endinterface

// File: rtl/sprite_scan_counter.sv
// Row-major col/row scan counter over a W x H sprite rectangle.
module sprite_scan_counter #(
    parameter int unsigned W = 4,
    parameter int unsigned H = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    output logic [3:0] col,
    output logic [3:0] row,
    output logic       last
);

    localparam logic [3:0] COL_MAX = 4'(W - 1);
    localparam logic [3:0] ROW_MAX = 4'(H - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    // Column advances every step; wraps into the next row at the right edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end

endmodule

// File: rtl/runner_sprite_drawer.sv
// Erases the runner at its previous row and redraws it at the new row,
// one pixel per cycle, on every accepted frame update.
module runner_sprite_drawer
    import runner_pkg::*;
#(
    parameter int unsigned X_POS         = 20,
    parameter int unsigned W             = 4,
    parameter int unsigned H             = 12,
    parameter logic [2:0]  RUNNER_COLOUR = COLOUR_RUNNER,
    parameter logic [2:0]  BG_COLOUR     = COLOUR_BG
) (
    input  logic                  clk,
    input  logic                  reset,
    runner_sprite_drawer_if.slave bus
);

    state_t     state, next_state;
    logic [6:0] y_prev, y_new;
    logic [3:0] col, row;
    logic       last;

    logic       cnt_clear, cnt_step, latch_y, commit_y, scan_pix;
    logic [6:0] scan_base;
    logic [2:0] scan_colour;
    logic [7:0] px_x, px_y;
    logic       in_bounds;

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;
    logic       plot_q, busy_q, done_q, overrun_q;

    sprite_scan_counter #(.W(W), .H(H)) u_scan (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .step  (cnt_step),
        .col   (col),
        .row   (row),
        .last  (last)
    );

    // Pixel coordinates are formed 8 bits wide so off-screen rows never wrap.
    assign px_x      = 8'(X_POS) + {4'b0, col};
    assign px_y      = {1'b0, scan_base} + {4'b0, row};
    assign in_bounds = (px_x < 8'(SCREEN_W)) && (px_y < 8'(SCREEN_H));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and scan control.
    always_comb begin
        next_state  = state;
        cnt_clear   = 1'b0;
        cnt_step    = 1'b0;
        latch_y     = 1'b0;
        commit_y    = 1'b0;
        scan_pix    = 1'b0;
        scan_base   = y_prev;
        scan_colour = BG_COLOUR;
        case (state)
            // busy_q is still high in the cycle done is shown; an update
            // then is an overrun, not a new frame.
            IDLE: if (bus.update && !busy_q) next_state = LATCH;
            LATCH: begin
                latch_y    = 1'b1;
                cnt_clear  = 1'b1;
                next_state = (bus.y_in != y_prev) ? ERASE : DRAW;
            end
            ERASE: begin
                scan_pix = 1'b1;
                cnt_step = 1'b1;
                if (last) begin
                    cnt_clear  = 1'b1;
                    next_state = DRAW;
                end
            end
            DRAW: begin
                scan_pix    = 1'b1;
                scan_base   = y_new;
                scan_colour = RUNNER_COLOUR;
                cnt_step    = 1'b1;
                if (last) begin
                    cnt_clear  = 1'b1;
                    commit_y   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Row registers: new row captured in LATCH, becomes previous once drawn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_prev <= GROUND_Y;
            y_new  <= GROUND_Y;
        end else begin
            if (latch_y)  y_new  <= bus.y_in;
            if (commit_y) y_prev <= y_new;
        end
    end

    // Registered pixel stream and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            x_q       <= scan_pix ? px_x : '0;
            y_q       <= scan_pix ? px_y[6:0] : '0;
            colour_q  <= scan_pix ? scan_colour : '0;
            plot_q    <= scan_pix && in_bounds;
            busy_q    <= (state != IDLE);
            done_q    <= (state == DONE);
            overrun_q <= bus.update && ((state != IDLE) || busy_q);
        end
    end

    assign bus.x_out   = x_q;
    assign bus.y_out   = y_q;
    assign bus.colour  = colour_q;
    assign bus.plot    = plot_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_runner_sprite_drawer.sv
// Self-checking bench for runner_sprite_drawer: directed table plus random
// frames, all checked cycle by cycle against a frame-level reference model.
module tb_runner_sprite_drawer;
    import runner_pkg::*;

    localparam int XP = 20;
    localparam int SW = 4;
    localparam int SH = 12;
    localparam int NPIX = SW * SH;

    logic clk = 1'b0;
    logic reset;

    runner_sprite_drawer_if bus ();

    runner_sprite_drawer #(
        .X_POS         (XP),
        .W             (SW),
        .H             (SH),
        .RUNNER_COLOUR (3'b111),
        .BG_COLOUR     (3'b000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_prev = 108;

    typedef struct {
        int y;          // y_in for the frame
        int inj;        // cycle offset of an extra update, -1 for none
        int exp_done;   // cycles from accepted update to done
        int exp_draws;  // plotted pixels in runner colour
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] observed(input logic want_coords);
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        x = want_coords ? bus.x_out  : 8'd0;
        y = want_coords ? bus.y_out  : 7'd0;
        c = want_coords ? bus.colour : 3'd0;
        return {bus.plot, x, y, c, bus.done, bus.busy, bus.overrun};
    endfunction

    // Runs one frame from an idle drawer. Expected stream: optional erase
    // rectangle at the old row, then draw rectangle at the new row.
    task automatic run_frame(input int y, input int j, input string tag,
                             output int act_done, output int act_draws);
        int erase_n, donek, kmax, idx, p, base, xx, yy;
        logic       e_plot, e_done, e_busy, e_ov;
        logic [2:0] e_col;
        logic [21:0] expv;
        erase_n  = (y != model_prev) ? NPIX : 0;
        donek    = 2 + erase_n + NPIX;
        kmax     = (j > donek) ? j : donek + 1;
        act_done = -1;
        act_draws = 0;
        bus.y_in   = 7'(y);
        bus.update = 1'b1;
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 0) bus.update = 1'b0;
            e_plot = 1'b0; e_col = 3'd0; xx = 0; yy = 0;
            idx = k - 2;
            if (idx >= 0 && idx < erase_n + NPIX) begin
                if (idx < erase_n) begin
                    base = model_prev; p = idx; e_col = 3'b000;
                end else begin
                    base = y; p = idx - erase_n; e_col = 3'b111;
                end
                xx = XP + p % SW;
                yy = base + p / SW;
                e_plot = (xx < 160) && (yy < 120);
            end
            e_done = (k == donek);
            e_busy = (k >= 1) && (k <= donek);
            e_ov   = (k == j);
            expv = e_plot ? {1'b1, 8'(xx), 7'(yy), e_col, e_done, e_busy, e_ov}
                          : {1'b0, 8'd0, 7'd0, 3'd0, e_done, e_busy, e_ov};
            check($sformatf("%s k=%0d", tag, k), 32'(observed(e_plot)), 32'(expv));
            if (bus.done && act_done < 0) act_done = k;
            if (bus.plot && bus.colour == 3'b111) act_draws++;
            if (k == j) bus.update = 1'b0;
            if (k + 1 == j) begin
                bus.update = 1'b1;
                bus.y_in   = 7'($urandom);
            end
        end
        model_prev = y;
    endtask

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ad, adr, y, j, donek;
        vecs[0] = '{108, -1, 50, 48};   // same row: no erase
        vecs[1] = '{99,  -1, 98, 48};   // move up: erase + draw
        vecs[2] = '{115, -1, 98, 20};   // bottom rows clipped
        vecs[3] = '{60,  60, 98, 48};   // overrun 10 cycles into DRAW
        vecs[4] = '{60,  51, 50, 48};   // overrun in the done cycle
        vecs[5] = '{108, -1, 98, 48};
        vecs[6] = '{90,  -1, 98, 48};   // back-to-back 108 -> 90 -> 108
        vecs[7] = '{108, -1, 98, 48};

        reset = 1'b0;
        bus.update = 1'b0;
        bus.y_in   = 7'd0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(observed(1'b1)), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_frame(vecs[i].y, vecs[i].inj, $sformatf("vec%0d", i), ad, adr);
            check($sformatf("vec%0d done_cycle", i), 32'(ad), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d draw_plots", i), 32'(adr), 32'(vecs[i].exp_draws));
        end

        // Reset in the middle of an erase scan: outputs clear at once.
        bus.y_in   = 7'd30;
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_erase", 32'(observed(1'b1)), 32'd0);
        @(negedge clk);
        check("reset_held", 32'(observed(1'b1)), 32'd0);
        reset = 1'b1;
        model_prev = 108;
        @(negedge clk);
        run_frame(108, -1, "post_reset", ad, adr);
        check("post_reset done_cycle", 32'(ad), 32'd50);

        // Random frames, including off-screen rows and random overruns.
        for (int r = 0; r < 16; r++) begin
            y = int'($urandom_range(0, 127));
            donek = 2 + ((y != model_prev) ? NPIX : 0) + NPIX;
            j = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, donek + 1)) : -1;
            run_frame(y, j, $sformatf("rnd%0d", r), ad, adr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
